// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - host-side sequencer for the sparse 4x4 spike-MVM engine
// Optional feature macro: MVM_SEQ_SKIP_ZERO_EN (all-zero trains bypass the engine).
module mvm_seq_ctrl #(
   parameter int MAX_NNZ     = 16,
   parameter int TRAIN_DEPTH = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     csr_wr,
   input  logic [1:0]               csr_row,
   input  logic [1:0]               csr_col,
   input  logic [7:0]               csr_val,
   input  logic                     csr_clear,
   output logic [$clog2(MAX_NNZ):0] nnz_count,
   input  logic                     train_wr,
   input  logic [3:0]               train_in,
   output logic                     train_full,
   input  logic                     run,
   output logic                     busy,
   output logic                     res_valid,
   output logic [1:0]               res_row,
   output logic [7:0]               res_data,
   output logic                     done,
   output logic                     err_timeout,
   output logic                     eng_start,
   input  logic                     eng_fetch_ready,
   output logic                     eng_sending,
   output logic                     eng_done_list,
   output logic [1:0]               eng_row,
   output logic [1:0]               eng_col,
   output logic [7:0]               eng_value,
   input  logic [7:0]               eng_out_val,
   input  logic                     eng_out_toggle
);

   localparam int CW = $clog2(MAX_NNZ) + 1;
   localparam int IW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
   localparam int FW = (TRAIN_DEPTH > 1) ? $clog2(TRAIN_DEPTH) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] NNZ_MAX = CW'(MAX_NNZ);
   localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

`ifdef MVM_SEQ_SKIP_ZERO_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_LIST_END  = 3'd3;
   localparam logic [2:0] S_TRAIN     = 3'd4;
   localparam logic [2:0] S_WAIT_DONE = 3'd5;
   localparam logic [2:0] S_COLLECT   = 3'd6;
   localparam logic [2:0] S_FINISH    = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] k_q, k_d;
   logic [CW-1:0] nnz_q, nnz_d;
   logic [1:0]    r_q, r_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          tog_ref_q, tog_ref_d;
   logic          skip_q, skip_d;
   logic [FW:0]   wr_ptr_q, wr_ptr_d;
   logic [FW:0]   rd_ptr_q, rd_ptr_d;

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_timeout_q, err_timeout_d;
   logic          res_valid_q, res_valid_d;
   logic [1:0]    res_row_q, res_row_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          eng_start_q, eng_start_d;
   logic          eng_sending_q, eng_sending_d;
   logic          eng_done_list_q, eng_done_list_d;
   logic [1:0]    eng_row_q, eng_row_d;
   logic [1:0]    eng_col_q, eng_col_d;
   logic [7:0]    eng_value_q, eng_value_d;

   logic [11:0]   csr_mem_q [MAX_NNZ];
   logic [3:0]    fifo_mem_q [TRAIN_DEPTH];

   logic          csr_we;
   logic          push;
   logic          pop;
   logic          flush;
   logic          fifo_empty;
   logic          fifo_full;
   logic [3:0]    fifo_head;
   logic          wd_watched;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) &&
                       (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
   assign fifo_head  = fifo_mem_q[rd_ptr_q[FW-1:0]];
   assign wd_watched = (state_q == S_LOAD) || (state_q == S_LIST_END) ||
                       (state_q == S_WAIT_DONE) || (state_q == S_COLLECT);

   always_comb begin
      state_d         = state_q;
      k_d             = k_q;
      r_d             = r_q;
      tog_ref_d       = tog_ref_q;
      skip_d          = skip_q;
      done_d          = 1'b0;
      err_timeout_d   = err_timeout_q;
      res_valid_d     = 1'b0;
      res_row_d       = res_row_q;
      res_data_d      = res_data_q;
      eng_start_d     = 1'b0;
      eng_sending_d   = 1'b0;
      eng_done_list_d = 1'b0;
      eng_row_d       = eng_row_q;
      eng_col_d       = eng_col_q;
      eng_value_d     = eng_value_q;
      pop             = 1'b0;
      flush           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               err_timeout_d = 1'b0;
               if (fifo_empty) done_d = 1'b1;
               else            state_d = S_START;
            end
         end
         S_START: begin
            k_d = '0;
            if (SKIP_ZERO && (fifo_head == 4'b0000)) begin
               pop     = 1'b1;
               skip_d  = 1'b1;
               r_d     = 2'd0;
               state_d = S_COLLECT;
            end else begin
               eng_start_d = 1'b1;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            // >= rather than == keeps a mid-load csr_clear from stranding the walk
            if (k_q >= nnz_q) begin
               state_d = S_LIST_END;
            end else if (eng_fetch_ready && !eng_sending_q) begin
               eng_sending_d                       = 1'b1;
               {eng_row_d, eng_col_d, eng_value_d} = csr_mem_q[k_q[IW-1:0]];
               k_d                                 = k_q + CW'(1);
            end
         end
         S_LIST_END: begin
            if (eng_fetch_ready && !eng_sending_q) begin
               eng_done_list_d = 1'b1;
               state_d         = S_TRAIN;
            end
         end
         S_TRAIN: begin
            eng_sending_d = 1'b1;
            eng_value_d   = {4'b0000, fifo_head};
            pop           = 1'b1;
            tog_ref_d     = eng_out_toggle;
            state_d       = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // first edge only marks compute completion; it carries no data
            if (eng_out_toggle != tog_ref_q) begin
               tog_ref_d = eng_out_toggle;
               r_d       = 2'd0;
               state_d   = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (skip_q || (eng_out_toggle != tog_ref_q)) begin
               tog_ref_d   = eng_out_toggle;
               res_valid_d = 1'b1;
               res_row_d   = r_q;
               res_data_d  = skip_q ? 8'h00 : eng_out_val;
               r_d         = r_q + 2'd1;
               if (r_q == 2'd3) begin
                  skip_d  = 1'b0;
                  state_d = fifo_empty ? S_FINISH : S_START;
               end
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (wd_watched && (wd_q == WD_MAX)) begin
         err_timeout_d   = 1'b1;
         flush           = 1'b1;
         done_d          = 1'b1;
         res_valid_d     = 1'b0;
         eng_sending_d   = 1'b0;
         eng_done_list_d = 1'b0;
         skip_d          = 1'b0;
         state_d         = S_IDLE;
      end

      wd_d   = (state_d != state_q) ? '0 : wd_q + WW'(1);
      busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);

      push     = train_wr && !fifo_full && !flush;
      wr_ptr_d = wr_ptr_q + {{FW{1'b0}}, push};
      rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + {{FW{1'b0}}, pop};

      csr_we = 1'b0;
      nnz_d  = nnz_q;
      if (csr_clear) begin
         nnz_d = '0;
      end else if (csr_wr && !busy_q && (nnz_q != NNZ_MAX)) begin
         csr_we = 1'b1;
         nnz_d  = nnz_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q         <= S_IDLE;
         k_q             <= '0;
         nnz_q           <= '0;
         r_q             <= '0;
         wd_q            <= '0;
         tog_ref_q       <= 1'b0;
         skip_q          <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_timeout_q   <= 1'b0;
         res_valid_q     <= 1'b0;
         res_row_q       <= '0;
         res_data_q      <= '0;
         eng_start_q     <= 1'b0;
         eng_sending_q   <= 1'b0;
         eng_done_list_q <= 1'b0;
         eng_row_q       <= '0;
         eng_col_q       <= '0;
         eng_value_q     <= '0;
      end else begin
         state_q         <= state_d;
         k_q             <= k_d;
         nnz_q           <= nnz_d;
         r_q             <= r_d;
         wd_q            <= wd_d;
         tog_ref_q       <= tog_ref_d;
         skip_q          <= skip_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_timeout_q   <= err_timeout_d;
         res_valid_q     <= res_valid_d;
         res_row_q       <= res_row_d;
         res_data_q      <= res_data_d;
         eng_start_q     <= eng_start_d;
         eng_sending_q   <= eng_sending_d;
         eng_done_list_q <= eng_done_list_d;
         eng_row_q       <= eng_row_d;
         eng_col_q       <= eng_col_d;
         eng_value_q     <= eng_value_d;
      end
   end

   always_ff @(posedge clk) begin
      if (csr_we) csr_mem_q[nnz_q[IW-1:0]] <= {csr_row, csr_col, csr_val};
      if (push)   fifo_mem_q[wr_ptr_q[FW-1:0]] <= train_in;
   end

   assign nnz_count     = nnz_q;
   assign train_full    = fifo_full;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_timeout   = err_timeout_q;
   assign res_valid     = res_valid_q;
   assign res_row       = res_row_q;
   assign res_data      = res_data_q;
   assign eng_start     = eng_start_q;
   assign eng_sending   = eng_sending_q;
   assign eng_done_list = eng_done_list_q;
   assign eng_row       = eng_row_q;
   assign eng_col       = eng_col_q;
   assign eng_value     = eng_value_q;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - scoreboard bench for mvm_seq_ctrl with a reactive engine model
module tb_mvm_seq_ctrl;
   localparam int MAX_NNZ     = 16;
   localparam int TRAIN_DEPTH = 4;
   localparam int TIMEOUT     = 255;
   localparam int MAXE        = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       csr_wr = 1'b0, csr_clear = 1'b0, train_wr = 1'b0, run = 1'b0;
   logic [1:0] csr_row = '0, csr_col = '0;
   logic [7:0] csr_val = '0;
   logic [3:0] train_in = '0;
   logic [4:0] nnz_count;
   logic       train_full, busy, res_valid, done, err_timeout;
   logic [1:0] res_row;
   logic [7:0] res_data;
   logic       eng_start, eng_sending, eng_done_list;
   logic [1:0] eng_row, eng_col;
   logic [7:0] eng_value;
   logic       eng_fetch_ready = 1'b0, eng_out_toggle = 1'b0;
   logic [7:0] eng_out_val = '0;

   mvm_seq_ctrl #(.MAX_NNZ(MAX_NNZ), .TRAIN_DEPTH(TRAIN_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .csr_wr(csr_wr), .csr_row(csr_row), .csr_col(csr_col),
      .csr_val(csr_val), .csr_clear(csr_clear), .nnz_count(nnz_count), .train_wr(train_wr),
      .train_in(train_in), .train_full(train_full), .run(run), .busy(busy),
      .res_valid(res_valid), .res_row(res_row), .res_data(res_data), .done(done),
      .err_timeout(err_timeout), .eng_start(eng_start), .eng_fetch_ready(eng_fetch_ready),
      .eng_sending(eng_sending), .eng_done_list(eng_done_list), .eng_row(eng_row),
      .eng_col(eng_col), .eng_value(eng_value), .eng_out_val(eng_out_val),
      .eng_out_toggle(eng_out_toggle)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   logic [1:0] m_row [MAX_NNZ];
   logic [1:0] m_col [MAX_NNZ];
   logic [7:0] m_val [MAX_NNZ];
   int         m_nnz = 0;
   int         m_fifo = 0;
   logic [9:0] exp_q [$];

   // engine model state
   bit         hang = 1'b0;
   int         ephase = 0, en = 0, eidx = 0, egap = 0, start_cnt = 0, train_cyc = 0;
   logic [1:0] erow [MAXE];
   logic [1:0] ecol [MAXE];
   logic [7:0] evalv [MAXE];
   logic [7:0] eacc [4];

   // monitor state
   int res_cnt = 0, done_cnt = 0, last_res_cyc = 0, done_cyc = 0, err_cyc = 0, seq_viol = 0;
   bit prev_sending = 1'b0, prev_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic void push_expected(input logic [3:0] t);
      for (int r = 0; r < 4; r++) begin
         int sum = 0;
         for (int e = 0; e < m_nnz; e++)
            if (int'(m_row[e]) == r && t[m_col[e]]) sum += int'(m_val[e]);
         exp_q.push_back({2'(r), 8'(sum)});
      end
   endfunction

   always begin
      @(posedge clk); #1;
      if (rst_n) begin
         ephase = 0; eng_fetch_ready = 1'b0; eng_out_toggle = 1'b0; eng_out_val = '0;
      end else begin
         eng_fetch_ready = ($urandom_range(0, 3) != 0);
         if (eng_start) begin
            ephase = 1; en = 0; start_cnt++;
         end else if (ephase == 1 && eng_sending) begin
            if (en < MAXE) begin erow[en] = eng_row; ecol[en] = eng_col; evalv[en] = eng_value; end
            en++;
         end else if (ephase == 1 && eng_done_list) begin
            ephase = 2;
         end else if (ephase == 2 && eng_sending) begin
            for (int r = 0; r < 4; r++) eacc[r] = 8'h00;
            for (int e = 0; e < en && e < MAXE; e++)
               if (eng_value[ecol[e]]) eacc[erow[e]] = eacc[erow[e]] + evalv[e];
            ephase = 3; eidx = -1; egap = $urandom_range(0, 4); train_cyc = cyc;
         end else if (ephase == 3) begin
            if (hang) ephase = 0;
            else if (egap > 0) egap--;
            else begin
               eng_out_val = (eidx >= 0) ? eacc[eidx] : 8'($urandom);
               eng_out_toggle = ~eng_out_toggle;
               eidx++;
               egap = $urandom_range(0, 2);
               if (eidx == 4) ephase = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         if (res_valid) begin
            checks++;
            res_cnt++;
            last_res_cyc = cyc;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL res_unexpected actual_row=%0d actual_data=%0d expected=none", res_row, res_data);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if ({res_row, res_data} !== e) begin
                  errors++;
                  $display("FAIL res_word actual_row=%0d actual_data=%0d expected_row=%0d expected_data=%0d",
                           res_row, res_data, e[9:8], e[7:0]);
               end
            end
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (err_timeout && !prev_err) err_cyc = cyc;
         if (eng_sending && prev_sending) seq_viol++;
      end
      prev_sending = eng_sending;
      prev_err = err_timeout;
   end

   task automatic csr_write(input logic [1:0] r, input logic [1:0] c, input logic [7:0] v);
      @(posedge clk); #1;
      csr_wr = 1'b1; csr_row = r; csr_col = c; csr_val = v;
      @(posedge clk); #1;
      csr_wr = 1'b0;
      if (m_nnz < MAX_NNZ) begin m_row[m_nnz] = r; m_col[m_nnz] = c; m_val[m_nnz] = v; m_nnz++; end
   endtask

   task automatic csr_clr();
      @(posedge clk); #1; csr_clear = 1'b1;
      @(posedge clk); #1; csr_clear = 1'b0;
      m_nnz = 0;
   endtask

   task automatic load_identity();
      csr_clr();
      for (int i = 0; i < 4; i++) csr_write(2'(i), 2'(i), 8'(i + 1));
   endtask

   task automatic push_train(input logic [3:0] t);
      @(posedge clk); #1; train_wr = 1'b1; train_in = t;
      @(posedge clk); #1; train_wr = 1'b0;
      if (m_fifo < TRAIN_DEPTH) begin
         m_fifo++;
         if (!hang) push_expected(t);
      end
   endtask

   task automatic run_batch(input string name, input int nres);
      int d0, r0, waited;
      d0 = done_cnt; r0 = res_cnt; waited = 0;
      @(posedge clk); #1; run = 1'b1;
      @(posedge clk); #1; run = 1'b0;
      while (done_cnt == d0 && waited < 4000) begin @(negedge clk); waited++; end
      chk({name, "_done_seen"}, (done_cnt != d0), 1);
      repeat (3) @(negedge clk);
      chk({name, "_done_once"}, done_cnt - d0, 1);
      chk({name, "_result_count"}, res_cnt - r0, nres);
      chk({name, "_scoreboard_drained"}, exp_q.size(), 0);
      if (nres > 0) chk({name, "_done_after_last_res"}, done_cyc - last_res_cyc, 1);
      exp_q.delete();
      m_fifo = 0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_time_limit actual=expired expected=finish");
      $fatal(1);
   end

   initial begin
      int s0, nt, n, waited;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_nnz_count", nnz_count, 0);
      chk("rst_train_full", train_full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_sending", eng_sending, 0);
      chk("rst_eng_done_list", eng_done_list, 0);
      chk("rst_eng_value", eng_value, 0);

      load_identity();
      chk("identity_nnz", nnz_count, 4);
      push_train(4'b1111);
      run_batch("identity_1111", 4);
      chk("identity_err_timeout", err_timeout, 0);

      push_train(4'b0101);
      push_train(4'b1010);
      run_batch("alternating_trains", 8);

      for (int i = 0; i < 4; i++) push_train(4'($urandom));
      @(negedge clk);
      chk("fifo_full_after_4", train_full, 1);
      push_train(4'b0110);
      run_batch("fifo_overflow", 16);
      chk("fifo_empty_after_batch", train_full, 0);

      s0 = start_cnt;
      push_train(4'b0000);
      run_batch("zero_train", 4);
`ifdef MVM_SEQ_SKIP_ZERO_EN
      chk("zero_train_eng_starts", start_cnt - s0, 0);
`else
      chk("zero_train_eng_starts", start_cnt - s0, 1);
`endif

      @(posedge clk); #1; csr_clear = 1'b1; csr_wr = 1'b1;
      @(posedge clk); #1; csr_clear = 1'b0; csr_wr = 1'b0;
      m_nnz = 0;
      @(negedge clk);
      chk("clear_beats_write", nnz_count, 0);

      for (int it = 0; it < 6; it++) begin
         csr_clr();
         n = (it == 0) ? 0 : $urandom_range(1, MAX_NNZ + 3);
         for (int j = 0; j < n; j++) csr_write(2'($urandom), 2'($urandom), 8'($urandom));
         @(negedge clk);
         chk("random_nnz_count", nnz_count, m_nnz);
         nt = $urandom_range(1, 5);
         for (int j = 0; j < nt; j++) push_train(4'($urandom));
         run_batch("random_batch", 4 * ((nt > TRAIN_DEPTH) ? TRAIN_DEPTH : nt));
      end

      hang = 1'b1;
      push_train(4'b1111);
      push_train(4'b0011);
      run_batch("watchdog", 0);
      chk("watchdog_err_set", err_timeout, 1);
      chk("watchdog_latency", err_cyc - train_cyc, TIMEOUT + 1);
      chk("watchdog_fifo_flushed", train_full, 0);
      hang = 1'b0;
      @(posedge clk); #1; run = 1'b1;
      @(posedge clk); #1; run = 1'b0;
      @(negedge clk);
      chk("empty_run_done", done, 1);
      chk("empty_run_busy", busy, 0);
      chk("empty_run_clears_err", err_timeout, 0);
      @(negedge clk);
      chk("empty_run_done_pulse", done, 0);

      csr_clr();
      for (int i = 0; i < MAX_NNZ; i++) csr_write(2'(i % 4), 2'(i / 4), 8'(i + 3));
      push_train(4'b1011);
      @(posedge clk); #1; run = 1'b1;
      @(posedge clk); #1; run = 1'b0;
      waited = 0;
      while (!(ephase == 1 && en >= 3) && waited < 500) begin @(negedge clk); waited++; end
      chk("abort_reached_load", (ephase == 1 && en >= 3), 1);
      rst_n = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_eng_sending", eng_sending, 0);
      chk("abort_eng_start", eng_start, 0);
      chk("abort_eng_value", eng_value, 0);
      chk("abort_nnz_count", nnz_count, 0);
      chk("abort_res_valid", res_valid, 0);
      exp_q.delete(); m_fifo = 0; m_nnz = 0;
      @(posedge clk); #1 rst_n = 1'b0;
      load_identity();
      push_train(4'($urandom));
      push_train(4'b1001);
      run_batch("after_abort", 8);

      chk("no_back_to_back_sending", seq_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Sequencer that drives the sparse 4x4 spike-MVM engine on behalf of the host. It holds a CSR entry buffer and a FIFO of 4-bit spike trains, then runs one engine transaction per queued train: start, CSR stream, list end, train, and collection of four result words. Row-tagged results go back to the host, and a watchdog bounds every engine wait. It sits between the host register interface and the MVM engine, which it owns exclusively.

## Interface
- MAX_NNZ, 16: CSR buffer depth (entries); count width is clog2(MAX_NNZ)+1
- TRAIN_DEPTH, 4: spike-train FIFO depth, power of two
- TIMEOUT, 255: max cycles spent waiting on any single engine event

Ports (reset rst_n, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high
- csr_wr  in  1  append {csr_row,csr_col,csr_val} to buffer
- csr_row  in  2  entry row
- csr_col  in  2  entry column
- csr_val  in  8  entry weight
- csr_clear  in  1  empty the CSR buffer (nnz_count := 0)
- nnz_count  out  5  buffered entries
- train_wr  in  1  push train_in into the FIFO
- train_in  in  4  spike train
- train_full  out  1  FIFO full
- run  in  1  pulse: process every queued train
- busy  out  1  high from run acceptance to done
- res_valid  out  1  one-cycle result strobe
- res_row  out  2  result row index
- res_data  out  8  result value
- done  out  1  one-cycle pulse, batch finished
- err_timeout  out  1  sticky watchdog flag, cleared by run
- eng_start  out  1  engine start
- eng_fetch_ready  in  1  engine ready for a word
- eng_sending  out  1  word valid to engine
- eng_done_list  out  1  end of CSR list
- eng_row  out  2  row to engine
- eng_col  out  2  column to engine
- eng_value  out  8  value to engine; train sent on [3:0], [7:4]=0
- eng_out_val  in  8  engine result word
- eng_out_toggle  in  1  engine output toggle line

## Operation
- All outputs reset to 0; state IDLE; FIFO and CSR buffer empty.
- csr_wr while busy, or with nnz_count==MAX_NNZ, is ignored. csr_clear takes priority over csr_wr in the same cycle.
- train_wr when full is dropped. Train push and pop in the same cycle are both performed.
- States and transitions:
  - IDLE -> START on run with FIFO non-empty. run with FIFO empty pulses done next cycle, busy stays 0.
  - START: eng_start=1 for one cycle -> LOAD; entry index k=0.
  - LOAD: when eng_fetch_ready=1 and eng_sending was 0 last cycle, drive entry k with eng_sending=1 for one cycle, then k++. When k==nnz_count -> LIST_END.
  - LIST_END: on eng_fetch_ready, eng_done_list=1 for one cycle -> TRAIN.
  - TRAIN: eng_sending=1 and eng_value=FIFO head for one cycle; pop FIFO; latch toggle reference -> WAIT_DONE.
  - WAIT_DONE: first change of eng_out_toggle (compute-complete marker, no data) -> COLLECT, r=0.
  - COLLECT: each further toggle change gives res_valid=1, res_row=r, res_data=eng_out_val in the cycle after detection, then r++. After r==3 -> FIFO non-empty ? START : FINISH.
  - FINISH: done=1, busy=0 -> IDLE.
- Watchdog: counter cleared on every state change. At TIMEOUT in LOAD, LIST_END, WAIT_DONE or COLLECT: set err_timeout, flush FIFO, pulse done, go to IDLE.
- nnz_count==0 is legal: LOAD passes straight to LIST_END.
- rst_n mid-transaction aborts immediately. Engine strobes return to 0 asynchronously.

## Timing
- res_valid occurs exactly 1 cycle after the toggle edge is sampled. Results per train come in order row 0..3 with no gaps beyond engine pacing.
- LOAD uses at least 2 cycles per entry, because eng_sending is never high on consecutive cycles.
- done comes 1 cycle after the last res_valid of the batch.
- run while busy is ignored.

## Configuration
- MVM_SEQ_SKIP_ZERO_EN defined: a FIFO head of 4'b0000 is popped without an engine transaction. The block emits four res_valid on consecutive cycles, rows 0..3, res_data=0, and eng_* stays idle.
- MVM_SEQ_SKIP_ZERO_EN undefined: zero trains run through the engine like any other train.

## Test plan
- Identity CSR (rows 0..3, col=row, val=1,2,3,4), train 4'b1111, run -> results rows 0..3 = 1,2,3,4; done once; err_timeout=0.
- Same CSR, trains 4'b0101 then 4'b1010 -> 1,0,3,0 then 0,2,0,4; one done after 8 res_valid.
- Engine model never toggles after train -> err_timeout=1 after TIMEOUT+1 cycles in WAIT_DONE; done pulses; FIFO empty; next run clears flag.
- Push 5 trains with TRAIN_DEPTH=4 -> train_full=1 after 4th, 5th dropped; run yields 16 results.
- Zero train with MVM_SEQ_SKIP_ZERO_EN -> eng_start never asserted, four zero results on consecutive cycles. Without the macro -> full engine handshake, zero results.
- rst_n asserted during LOAD -> all outputs 0 at once; nnz_count=0; a later run on reloaded data produces correct results.
